// File: rtl/ysyx_22041752_msu_pkg.sv
// Shared widths, encodings and bus layouts for the ysyx_22041752 memory stage.
// Latency: n/a (declarations and pure combinational helpers only).
// Backpressure: n/a.
//
// Contents:
//   - bus widths (ES->MS, MS->WS, forward), register-file and PC widths
//   - memory access size encodings
//   - FSM state encoding for the memory stage
//   - packed layouts of the inter-stage buses
//   - store strobe / data replication helpers
package ysyx_22041752_msu_pkg;

    localparam int PC_WD           = 64;
    localparam int RF_ADDR_WD      = 5;
    localparam int RF_DATA_WD      = 64;
    localparam int ES_TO_MS_BUS_WD = 203;
    localparam int MS_TO_WS_BUS_WD = 134;
    localparam int FORWARD_BUS_WD  = 70;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;
    localparam logic [1:0] MEM_D = 2'b11;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_RESP = 2'd2,
        MS_DONE = 2'd3
    } ms_state_e;

    // First member is the MSB of the flat bus.
    typedef struct packed {
        logic                  ld;
        logic                  st;
        logic [1:0]            size;
        logic                  uns;
        logic                  rf_we;
        logic [RF_ADDR_WD-1:0] rd;
        logic [RF_DATA_WD-1:0] alu_r;
        logic [RF_DATA_WD-1:0] st_data;
        logic [PC_WD-1:0]      pc;
    } es_to_ms_t;

    typedef struct packed {
        logic                  rf_we;
        logic [RF_ADDR_WD-1:0] rd;
        logic [RF_DATA_WD-1:0] ms_r;
        logic [PC_WD-1:0]      pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic                  fwd_valid;
        logic [RF_DATA_WD-1:0] ms_r;
        logic [RF_ADDR_WD-1:0] rd;
    } ms_fwd_t;

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [7:0] st_strb(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] r;
        case (size)
            MEM_B:   r = 8'h01 << off;
            MEM_H:   r = 8'h03 << off;
            MEM_W:   r = 8'h0F << off;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // Store data replicated across the doubleword so any lane selected by
    // the strobes carries the right bytes, independent of the offset.
    function automatic logic [63:0] st_wdata(input logic [1:0] size, input logic [63:0] d);
        logic [63:0] r;
        case (size)
            MEM_B:   r = {8{d[7:0]}};
            MEM_H:   r = {4{d[15:0]}};
            MEM_W:   r = {2{d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22041752_ld_ext.sv
// Load data aligner: shifts the returned doubleword down by the byte offset and sign/zero extends.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows inputs.
//
// Ports:
//   i_rdata  [63:0]  aligned doubleword from memory
//   i_off    [2:0]   byte offset within the doubleword
//   i_size   [1:0]   access size (B/H/W/D)
//   i_uns            1 = zero-extend, 0 = sign-extend
//   o_result [63:0]  register-file value
module ysyx_22041752_ld_ext
    import ysyx_22041752_msu_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [63:0] o_result
);

    logic [63:0] w_sh;

    assign w_sh = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_result = w_sh;
        case (i_size)
            MEM_B: o_result = i_uns ? {56'd0, w_sh[7:0]}
                                    : {{56{w_sh[7]}}, w_sh[7:0]};
            MEM_H: o_result = i_uns ? {48'd0, w_sh[15:0]}
                                    : {{48{w_sh[15]}}, w_sh[15:0]};
            MEM_W: o_result = i_uns ? {32'd0, w_sh[31:0]}
                                    : {{32{w_sh[31]}}, w_sh[31:0]};
            default: o_result = w_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22041752_msu.sv
// Memory stage: issues one load/store over the req/addr_ok/data_ok handshake, then hands the result to WBU.
// Latency: non-memory ops 1 cycle in stage; memory ops >= 3 cycles (REQ, RESP, DONE).
// Backpressure: ms_allowin low while an access is in flight or WBU stalls; result and bus held.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   ms_allowin               stage can take a new instruction
//   es_to_ms_valid/_bus      instruction from EXU
//   ws_allowin               WBU can accept
//   ms_to_ws_valid/_bus      result to WBU {rf_we, rd, ms_r, pc}
//   ms_forward_bus           {fwd_valid, ms_r, rd} to the decoder
//   ms_ld_block              load result not yet forwardable; decoder stalls on rd match
//   data_sram_*              data memory request/response channel
//
// Build option: define YSYX_22041752_LOAD_FWD_EN to forward load data once it
// has returned (DONE state). Without it, load results are never forwarded
// from this stage and ms_ld_block covers the full residency of the load.
module ysyx_22041752_msu
    import ysyx_22041752_msu_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,

    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,

    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,

    output logic [FORWARD_BUS_WD-1:0]  ms_forward_bus,
    output logic                       ms_ld_block,

    output logic                       data_sram_req,
    output logic                       data_sram_wr,
    output logic [1:0]                 data_sram_size,
    output logic [63:0]                data_sram_addr,
    output logic [7:0]                 data_sram_wstrb,
    output logic [63:0]                data_sram_wdata,
    input  logic                       data_sram_addr_ok,
    input  logic                       data_sram_data_ok,
    input  logic [63:0]                data_sram_rdata
);

    logic        r_ms_valid;
    es_to_ms_t   r_bus;
    ms_state_e   r_state;
    ms_state_e   w_next_state;
    logic [63:0] r_rdata;

    es_to_ms_t   w_in;
    logic        w_in_mem;
    logic        w_is_mem;
    logic        w_ready_go;
    logic        w_capture;
    logic [2:0]  w_off;
    logic [63:0] w_ld_data;
    logic [63:0] w_ms_r;
    logic        w_fwd_valid;
    ms_to_ws_t   w_ws_bus;
    ms_fwd_t     w_fwd_bus;

    assign w_in     = es_to_ms_t'(es_to_ms_bus);
    assign w_in_mem = w_in.ld | w_in.st;
    assign w_is_mem = r_bus.ld | r_bus.st;
    assign w_off    = r_bus.alu_r[2:0];

    // ------------------------------------------------------------------
    // Handshake with neighbouring stages
    // ------------------------------------------------------------------
    assign w_ready_go     = !w_is_mem || (r_state == MS_DONE);
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_capture      = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register carries no reset: it is qualified by r_ms_valid.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_bus <= w_in;
        end
    end

    // ------------------------------------------------------------------
    // Memory access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_capture) begin
            // Covers both an empty stage and DONE/non-mem draining into a
            // new instruction on the same edge.
            if (w_in_mem) begin
                w_next_state = MS_REQ;
            end else begin
                w_next_state = MS_IDLE;
            end
        end else if (r_ms_valid) begin
            if (ms_allowin) begin
                // Instruction leaves with nothing behind it.
                w_next_state = MS_IDLE;
            end else begin
                case (r_state)
                    MS_REQ:  if (data_sram_addr_ok) w_next_state = MS_RESP;
                    MS_RESP: if (data_sram_data_ok) w_next_state = MS_DONE;
                    default: w_next_state = r_state;
                endcase
            end
        end
    end

    // Response capture; data_ok outside RESP is not ours and is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 64'd0;
        end else if (r_ms_valid && (r_state == MS_RESP) && data_sram_data_ok) begin
            r_rdata <= data_sram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Data memory request: everything comes from r_bus, so it is stable
    // for as long as req waits on addr_ok.
    // ------------------------------------------------------------------
    assign data_sram_req   = r_ms_valid && (r_state == MS_REQ);
    assign data_sram_wr    = r_bus.st;
    assign data_sram_size  = r_bus.size;
    assign data_sram_addr  = r_bus.alu_r;
    assign data_sram_wstrb = r_bus.st ? st_strb(r_bus.size, w_off) : 8'h00;
    assign data_sram_wdata = st_wdata(r_bus.size, r_bus.st_data);

    // ------------------------------------------------------------------
    // Load alignment and result selection
    // ------------------------------------------------------------------
    ysyx_22041752_ld_ext u_ld_ext (
        .i_rdata  (r_rdata),
        .i_off    (w_off),
        .i_size   (r_bus.size),
        .i_uns    (r_bus.uns),
        .o_result (w_ld_data)
    );

    assign w_ms_r = r_bus.ld ? w_ld_data : r_bus.alu_r;

    always_comb begin
        w_ws_bus       = '0;
        w_ws_bus.rf_we = r_bus.rf_we && !r_bus.st;
        w_ws_bus.rd    = r_bus.rd;
        w_ws_bus.ms_r  = w_ms_r;
        w_ws_bus.pc    = r_bus.pc;
    end

    assign ms_to_ws_bus = w_ws_bus;

    // ------------------------------------------------------------------
    // Forwarding to the decoder
    // ------------------------------------------------------------------
`ifdef YSYX_22041752_LOAD_FWD_EN
    // Load data is valid once latched, i.e. from DONE onwards.
    assign w_fwd_valid = r_ms_valid && r_bus.rf_we && (!r_bus.ld || (r_state == MS_DONE));
`else
    assign w_fwd_valid = r_ms_valid && r_bus.rf_we && !r_bus.ld;
`endif

    assign ms_ld_block = r_ms_valid && r_bus.ld && r_bus.rf_we && !w_fwd_valid;

    always_comb begin
        w_fwd_bus           = '0;
        w_fwd_bus.fwd_valid = w_fwd_valid;
        w_fwd_bus.ms_r      = w_ms_r;
        w_fwd_bus.rd        = r_bus.rd;
    end

    assign ms_forward_bus = w_fwd_bus;

endmodule

// File: tb/tb_ysyx_22041752_msu.sv
// Directed self-checking bench for the memory stage.
// Latency: n/a.
// Backpressure: drives ws_allowin and addr_ok/data_ok by hand per scenario.
module tb_ysyx_22041752_msu;
    import ysyx_22041752_msu_pkg::*;

`ifdef YSYX_22041752_LOAD_FWD_EN
    localparam bit LD_FWD = 1'b1;
`else
    localparam bit LD_FWD = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [FORWARD_BUS_WD-1:0]  ms_forward_bus;
    logic                       ms_ld_block;
    logic                       data_sram_req;
    logic                       data_sram_wr;
    logic [1:0]                 data_sram_size;
    logic [63:0]                data_sram_addr;
    logic [7:0]                 data_sram_wstrb;
    logic [63:0]                data_sram_wdata;
    logic                       data_sram_addr_ok;
    logic                       data_sram_data_ok;
    logic [63:0]                data_sram_rdata;

    int errors = 0;
    int checks = 0;
    int xfer_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ms_to_ws_valid && ws_allowin) xfer_cnt <= xfer_cnt + 1;
    end

    ysyx_22041752_msu dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward_bus    (ms_forward_bus),
        .ms_ld_block       (ms_ld_block),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    // Output bus fields: {rf_we[133], rd[132:128], ms_r[127:64], pc[63:0]}
    logic        o_rf_we;
    logic [4:0]  o_rd;
    logic [63:0] o_ms_r;
    logic        o_fwd;
    assign o_rf_we = ms_to_ws_bus[133];
    assign o_rd    = ms_to_ws_bus[132:128];
    assign o_ms_r  = ms_to_ws_bus[127:64];
    assign o_fwd   = ms_forward_bus[69];

    function automatic logic [ES_TO_MS_BUS_WD-1:0] mk_bus(
        input logic ld, input logic st, input logic [1:0] size, input logic uns,
        input logic rf_we, input logic [4:0] rd, input logic [63:0] alu_r,
        input logic [63:0] st_data, input logic [63:0] pc);
        return {ld, st, size, uns, rf_we, rd, alu_r, st_data, pc};
    endfunction

    // Load table: size, uns, address, returned doubleword, expected result
    localparam logic [1:0]  LD_SZ  [6] = '{MEM_B, MEM_B, MEM_H, MEM_W, MEM_W, MEM_D};
    localparam logic        LD_UNS [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [63:0] LD_AD  [6] = '{64'h80000003, 64'h80000003, 64'h80000002,
                                           64'h80000004, 64'h80000004, 64'h80000000};
    localparam logic [63:0] LD_RD  [6] = '{64'h00000000_80000000, 64'h00000000_80000000,
                                           64'h00000000_80010000, 64'hF0000001_00000000,
                                           64'hF0000001_00000000, 64'h01234567_89ABCDEF};
    localparam logic [63:0] LD_EXP [6] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_00000080,
                                           64'hFFFFFFFF_FFFF8001, 64'h00000000_F0000001,
                                           64'hFFFFFFFF_F0000001, 64'h01234567_89ABCDEF};

    // Store table: size, address, store data, expected strobe, expected wdata
    localparam logic [1:0]  ST_SZ  [4] = '{MEM_W, MEM_B, MEM_H, MEM_D};
    localparam logic [63:0] ST_AD  [4] = '{64'h80000004, 64'h80000005, 64'h80000002, 64'h80000000};
    localparam logic [63:0] ST_DAT [4] = '{64'h00000000_DEADBEEF, 64'h00000000_000000AB,
                                           64'h00000000_00001234, 64'h01020304_05060708};
    localparam logic [7:0]  ST_STB [4] = '{8'hF0, 8'h20, 8'h0C, 8'hFF};
    localparam logic [63:0] ST_WD  [4] = '{64'hDEADBEEF_DEADBEEF, 64'hABABABAB_ABABABAB,
                                           64'h12341234_12341234, 64'h01020304_05060708};

    // Present one instruction for one cycle; returns in the cycle after capture.
    task automatic issue(input logic [ES_TO_MS_BUS_WD-1:0] b);
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        ws_allowin = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 64'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ms_to_ws_valid); end
        checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", data_sram_req); end
        checks++; if (ms_ld_block !== 1'b0) begin errors++; $display("FAIL reset_ldblk: got %b want 0", ms_ld_block); end
        checks++; if (o_fwd !== 1'b0) begin errors++; $display("FAIL reset_fwd: got %b want 0", o_fwd); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
    endtask

    task automatic test_nonmem;
        issue(mk_bus(1'b0, 1'b0, MEM_D, 1'b0, 1'b1, 5'd5, 64'h1234, 64'h0, 64'h80000000));
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL nm_valid: got %b want 1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus !== {1'b1, 5'd5, 64'h1234, 64'h80000000}) begin errors++; $display("FAIL nm_bus: got %h want %h", ms_to_ws_bus, {1'b1, 5'd5, 64'h1234, 64'h80000000}); end
        checks++; if (ms_forward_bus !== {1'b1, 64'h1234, 5'd5}) begin errors++; $display("FAIL nm_fwd: got %h want %h", ms_forward_bus, {1'b1, 64'h1234, 5'd5}); end
        checks++; if (data_sram_req !== 1'b0) begin errors++; $display("FAIL nm_req: got %b want 0", data_sram_req); end
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL nm_drain: got %b want 0", ms_to_ws_valid); end
    endtask

    task automatic test_load_ext;
        for (int i = 0; i < 6; i++) begin
            issue(mk_bus(1'b1, 1'b0, LD_SZ[i], LD_UNS[i], 1'b1, 5'd10, LD_AD[i], 64'h0, 64'h80001000));
            checks++; if (data_sram_req !== 1'b1 || data_sram_wr !== 1'b0 || data_sram_addr !== LD_AD[i] || data_sram_wstrb !== 8'h00) begin
                errors++; $display("FAIL ld_req[%0d]: got req=%b wr=%b addr=%h strb=%h want 1 0 %h 00", i, data_sram_req, data_sram_wr, data_sram_addr, data_sram_wstrb, LD_AD[i]); end
            data_sram_addr_ok = 1'b1;
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            checks++; if (data_sram_req !== 1'b0 || ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ld_resp[%0d]: got req=%b valid=%b want 0 0", i, data_sram_req, ms_to_ws_valid); end
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = LD_RD[i];
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 64'hA5A5A5A5_A5A5A5A5;
            checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ld_valid[%0d]: got %b want 1", i, ms_to_ws_valid); end
            checks++; if (o_ms_r !== LD_EXP[i]) begin errors++; $display("FAIL ld_data[%0d]: got %h want %h", i, o_ms_r, LD_EXP[i]); end
            @(negedge clk);
            checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL ld_drain[%0d]: got %b want 0", i, ms_to_ws_valid); end
        end
    endtask

    task automatic test_store;
        for (int i = 0; i < 4; i++) begin
            issue(mk_bus(1'b0, 1'b1, ST_SZ[i], 1'b0, 1'b1, 5'd12, ST_AD[i], ST_DAT[i], 64'h80002000));
            checks++; if (data_sram_req !== 1'b1 || data_sram_wr !== 1'b1 || data_sram_size !== ST_SZ[i]) begin
                errors++; $display("FAIL st_req[%0d]: got req=%b wr=%b size=%0d want 1 1 %0d", i, data_sram_req, data_sram_wr, data_sram_size, ST_SZ[i]); end
            checks++; if (data_sram_wstrb !== ST_STB[i]) begin errors++; $display("FAIL st_wstrb[%0d]: got %h want %h", i, data_sram_wstrb, ST_STB[i]); end
            checks++; if (data_sram_wdata !== ST_WD[i]) begin errors++; $display("FAIL st_wdata[%0d]: got %h want %h", i, data_sram_wdata, ST_WD[i]); end
            data_sram_addr_ok = 1'b1;
            @(negedge clk);
            data_sram_addr_ok = 1'b0;
            data_sram_data_ok = 1'b1;
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            checks++; if (ms_to_ws_valid !== 1'b1 || o_rf_we !== 1'b0 || o_ms_r !== ST_AD[i]) begin
                errors++; $display("FAIL st_done[%0d]: got valid=%b rf_we=%b ms_r=%h want 1 0 %h", i, ms_to_ws_valid, o_rf_we, o_ms_r, ST_AD[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_addr_stall;
        issue(mk_bus(1'b1, 1'b0, MEM_W, 1'b0, 1'b1, 5'd3, 64'h80000010, 64'h11223344_55667788, 64'h80003000));
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 64'h80000010) begin errors++; $display("FAIL stall_req[%0d]: got req=%b addr=%h want 1 80000010", i, data_sram_req, data_sram_addr); end
            checks++; if (data_sram_wdata !== 64'h55667788_55667788 || data_sram_wstrb !== 8'h00) begin errors++; $display("FAIL stall_wd[%0d]: got %h/%h want 5566778855667788/00", i, data_sram_wdata, data_sram_wstrb); end
            checks++; if (ms_allowin !== 1'b0 || ms_ld_block !== 1'b1) begin errors++; $display("FAIL stall_hs[%0d]: got allowin=%b ldblk=%b want 0 1", i, ms_allowin, ms_ld_block); end
            // A waiting upstream instruction must not be taken.
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk_bus(1'b0, 1'b1, MEM_B, 1'b0, 1'b0, 5'd1, 64'h90000000, 64'hFF, 64'h0);
            @(negedge clk);
        end
        es_to_ms_valid = 1'b0;
        checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 64'h80000010) begin errors++; $display("FAIL stall_hold: got req=%b addr=%h want 1 80000010", data_sram_req, data_sram_addr); end
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 64'h00000000_CAFEF00D;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        checks++; if (ms_to_ws_valid !== 1'b1 || o_ms_r !== 64'hFFFFFFFF_CAFEF00D || o_rd !== 5'd3) begin
            errors++; $display("FAIL stall_done: got valid=%b ms_r=%h rd=%0d want 1 ffffffffcafef00d 3", ms_to_ws_valid, o_ms_r, o_rd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int x0;
        logic [MS_TO_WS_BUS_WD-1:0] exp_bus;
        exp_bus = {1'b1, 5'd9, 64'h01234567_89ABCDEF, 64'h80000100};
        issue(mk_bus(1'b1, 1'b0, MEM_D, 1'b0, 1'b1, 5'd9, 64'h80000020, 64'h0, 64'h80000100));
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 64'h01234567_89ABCDEF;
        @(negedge clk);
        x0 = xfer_cnt;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== exp_bus) begin errors++; $display("FAIL wsst_bus[%0d]: got valid=%b bus=%h want 1 %h", i, ms_to_ws_valid, ms_to_ws_bus, exp_bus); end
            checks++; if (data_sram_req !== 1'b0 || ms_allowin !== 1'b0) begin errors++; $display("FAIL wsst_req[%0d]: got req=%b allowin=%b want 0 0", i, data_sram_req, ms_allowin); end
            checks++; if (ms_ld_block !== !LD_FWD || o_fwd !== LD_FWD) begin errors++; $display("FAIL wsst_fwd[%0d]: got ldblk=%b fwd=%b want %b %b", i, ms_ld_block, o_fwd, !LD_FWD, LD_FWD); end
            // Stray responses while holding must not disturb the result.
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 64'hDEAD0000_0000BEEF;
            @(negedge clk);
        end
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk_bus(1'b1, 1'b0, MEM_B, 1'b1, 1'b1, 5'd11, 64'h80000040, 64'h0, 64'h80000104);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL b2b_xfers: got %0d want 1", xfer_cnt - x0); end
        checks++; if (data_sram_req !== 1'b1 || data_sram_addr !== 64'h80000040 || ms_to_ws_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_req: got req=%b addr=%h valid=%b want 1 80000040 0", data_sram_req, data_sram_addr, ms_to_ws_valid); end
    endtask

    // Continues from the request left in flight by test_back_to_back.
    task automatic test_reset_mid;
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        data_sram_addr_ok = 1'b0;
        checks++; if (data_sram_req !== 1'b0 || ms_allowin !== 1'b0) begin errors++; $display("FAIL rm_resp: got req=%b allowin=%b want 0 0", data_sram_req, ms_allowin); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ms_to_ws_valid !== 1'b0 || data_sram_req !== 1'b0) begin errors++; $display("FAIL rm_idle: got valid=%b req=%b want 0 0", ms_to_ws_valid, data_sram_req); end
        checks++; if (ms_allowin !== 1'b1 || ms_ld_block !== 1'b0) begin errors++; $display("FAIL rm_hs: got allowin=%b ldblk=%b want 1 0", ms_allowin, ms_ld_block); end
        data_sram_data_ok = 1'b1;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        checks++; if (ms_to_ws_valid !== 1'b0 || data_sram_req !== 1'b0) begin errors++; $display("FAIL rm_stale: got valid=%b req=%b want 0 0", ms_to_ws_valid, data_sram_req); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_ext();
        test_store();
        test_addr_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
